// File: rtl/lf_conf_spi.sv
// SPI config receiver oversampled in pck0: 16-bit command frames write NUM_REGS registers, miso reads one back.
// Latency: regs/upd update 4-5 pck0 cycles after the ncs pin rises; no backpressure (SPI master must respect spck <= pck0/4).
`timescale 1ns/1ps
module lf_conf_spi #(
  parameter int                NUM_REGS  = 4,
  parameter int                DATA_W    = 8,
  parameter int                FRAME_W   = 16,
  parameter logic [DATA_W-1:0] ED_CONF   = DATA_W'(8'h01),
  parameter logic [DATA_W-1:0] ED_THRESH = DATA_W'(8'd127)
) (
  input  logic                       pck0,
  input  logic                       nrst,
  input  logic                       spck,
  input  logic                       mosi,
  input  logic                       ncs,
  output logic                       miso,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        upd,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  state_t             state;
  logic [2:0]         spck_s;
  logic [2:0]         ncs_s;
  logic [1:0]         mosi_s;
  logic [FRAME_W-1:0] rx_sr;
  logic [FRAME_W-2:0] tx_sr;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         rb_idx;
  logic [DATA_W-1:0]  reg_q [NUM_REGS];

  logic               spck_rise, spck_fall, ncs_rise, ncs_fall;
  logic [3:0]         cmd;
  logic [DATA_W-1:0]  d;
  logic [DATA_W-1:0]  rb_data;
  logic [FRAME_W-1:0] rb_word;

  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      spck_s <= '0;
      ncs_s  <= '0;
      mosi_s <= '0;
    end else begin
      spck_s <= {spck_s[1:0], spck};
      ncs_s  <= {ncs_s[1:0], ncs};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  assign spck_rise = spck_s[1] & ~spck_s[2];
  assign spck_fall = ~spck_s[1] & spck_s[2];
  assign ncs_rise  = ncs_s[1] & ~ncs_s[2];
  assign ncs_fall  = ~ncs_s[1] & ncs_s[2];

  assign cmd = rx_sr[FRAME_W-1 -: 4];
  assign d   = rx_sr[DATA_W-1:0];

  // Out-of-range readback indices fall through to zero data.
  always_comb begin
    rb_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rb_idx == 4'(i)) rb_data = reg_q[i];
    rb_word = '0;
    rb_word[FRAME_W-1 -: 4] = rb_idx;
    rb_word[DATA_W-1:0]     = rb_data;
  end

  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      state     <= WAIT_IDLE;
      rx_sr     <= '0;
      tx_sr     <= '0;
      cnt       <= '0;
      rb_idx    <= '0;
      miso      <= 1'b0;
      busy      <= 1'b0;
      upd       <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
    end else begin
      upd       <= '0;
      frame_err <= 1'b0;
      case (state)
        WAIT_IDLE: if (ncs_s[1]) state <= IDLE;
        IDLE: begin
          if (ncs_fall) begin
            state <= SHIFT;
            busy  <= 1'b1;
            cnt   <= '0;
            rx_sr <= '0;
            tx_sr <= rb_word[FRAME_W-2:0];
            miso  <= rb_word[FRAME_W-1];
          end
        end
        SHIFT: begin
          // ncs rise takes priority; a coincident spck edge is dropped.
          if (ncs_rise) begin
            state <= COMMIT;
            busy  <= 1'b0;
            miso  <= 1'b0;
          end else begin
            if (spck_rise) begin
              rx_sr <= {rx_sr[FRAME_W-2:0], mosi_s[1]};
              if (cnt != CNT_W'(FRAME_W)) cnt <= cnt + 1'b1;
            end
            if (spck_fall) begin
              miso  <= tx_sr[FRAME_W-2];
              tx_sr <= {tx_sr[FRAME_W-3:0], 1'b0};
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (cnt != CNT_W'(FRAME_W)) begin
            frame_err <= 1'b1;
          end else if (cmd == 4'hF) begin
            rb_idx <= d[3:0];
          end else if (cmd != 4'd0) begin
            if (cmd <= 4'(NUM_REGS)) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (cmd == 4'(i + 1)) begin
                  reg_q[i] <= d;
                  upd[i]   <= 1'b1;
                end
                // Writing ED_CONF to conf_word also restores the default threshold.
                if (i == 2 && cmd == 4'd1 && d == ED_CONF) begin
                  reg_q[i] <= ED_THRESH;
                  upd[i]   <= 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = reg_q[g];
  end

endmodule

// File: tb/tb_lf_conf_spi.sv
// Directed bench for lf_conf_spi: table of SPI frames with expected register/strobe/readback results.
`timescale 1ns/1ps
module tb_lf_conf_spi;

  logic        pck0 = 1'b0;
  logic        nrst = 1'b0;
  logic        spck = 1'b0;
  logic        mosi = 1'b0;
  logic        ncs  = 1'b1;
  logic        miso;
  logic [31:0] regs;
  logic [3:0]  upd;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  lf_conf_spi dut (
    .pck0      (pck0),
    .nrst      (nrst),
    .spck      (spck),
    .mosi      (mosi),
    .ncs       (ncs),
    .miso      (miso),
    .regs      (regs),
    .upd       (upd),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 pck0 = ~pck0;

  typedef struct {
    logic [31:0] bits;
    int          n;
    logic [31:0] exp_regs;
    logic [3:0]  exp_upd;
    logic        exp_err;
    logic        chk_rd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pck0);
  endtask

  // Mode-0 style: mosi changes while spck low, miso sampled just before each rise.
  task automatic shift_bits(input logic [31:0] bits, input int n, output logic [15:0] rd);
    rd = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      cyc(5);
      rd = {rd[14:0], miso};
      spck = 1'b1;
      cyc(5);
      spck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, output logic [15:0] rd);
    ncs = 1'b0;
    cyc(5);
    shift_bits(bits, n, rd);
    cyc(5);
    ncs = 1'b1;
  endtask

  task automatic observe(output logic [3:0] first_upd, output int upd_cycles,
                         output int lat, output int err_cycles);
    first_upd  = '0;
    upd_cycles = 0;
    lat        = 0;
    err_cycles = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc(1);
      if (upd != 4'd0) begin
        if (upd_cycles == 0) begin
          first_upd = upd;
          lat       = c;
        end
        upd_cycles++;
      end
      if (frame_err) begin
        err_cycles++;
        if (lat == 0) lat = c;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [3:0]  fu;
    int          uc, lat, ec;

    vecs[0]  = '{32'h205F,  16, 32'h00005F00, 4'b0010, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{32'h1001,  16, 32'h007F5F01, 4'b0101, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{32'h3040,  16, 32'h00405F01, 4'b0100, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{32'h2011,  15, 32'h00405F01, 4'b0000, 1'b1, 1'b0, 16'h0000};
    vecs[4]  = '{32'h120AA, 17, 32'h0040AA01, 4'b0010, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{32'h40C3,  16, 32'hC340AA01, 4'b1000, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{32'hF003,  16, 32'hC340AA01, 4'b0000, 1'b0, 1'b1, 16'h0001};
    vecs[7]  = '{32'h0000,  16, 32'hC340AA01, 4'b0000, 1'b0, 1'b1, 16'h30C3};
    vecs[8]  = '{32'hF009,  16, 32'hC340AA01, 4'b0000, 1'b0, 1'b1, 16'h30C3};
    vecs[9]  = '{32'h0000,  16, 32'hC340AA01, 4'b0000, 1'b0, 1'b1, 16'h9000};
    vecs[10] = '{32'h5077,  16, 32'hC340AA01, 4'b0000, 1'b1, 1'b0, 16'h0000};
    vecs[11] = '{32'h1002,  16, 32'hC340AA02, 4'b0001, 1'b0, 1'b1, 16'h9000};
    vecs[12] = '{32'hF001,  16, 32'hC340AA02, 4'b0000, 1'b0, 1'b0, 16'h0000};
    vecs[13] = '{32'h0000,  16, 32'hC340AA02, 4'b0000, 1'b0, 1'b1, 16'h10AA};

    // Reset with ncs held low: the in-flight frame must be ignored.
    ncs = 1'b0;
    cyc(3);
    chk("reset regs", regs, 32'h0);
    chk("reset miso", {31'h0, miso}, 32'h0);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset upd", {28'h0, upd}, 32'h0);
    nrst = 1'b1;
    cyc(3);
    shift_bits(32'h2033, 16, rd);
    chk("wait_idle busy", {31'h0, busy}, 32'h0);
    cyc(5);
    ncs = 1'b1;
    observe(fu, uc, lat, ec);
    chk("wait_idle upd", uc, 0);
    chk("wait_idle err", ec, 0);
    chk("wait_idle regs", regs, 32'h0);

    for (int k = 0; k < 14; k++) begin
      send_frame(vecs[k].bits, vecs[k].n, rd);
      observe(fu, uc, lat, ec);
      chk($sformatf("v%0d regs", k), regs, vecs[k].exp_regs);
      chk($sformatf("v%0d upd", k), {28'h0, fu}, {28'h0, vecs[k].exp_upd});
      chk($sformatf("v%0d upd_cycles", k), uc, (vecs[k].exp_upd != 4'd0) ? 1 : 0);
      chk($sformatf("v%0d err_cycles", k), ec, {31'h0, vecs[k].exp_err});
      if (vecs[k].exp_upd != 4'd0 || vecs[k].exp_err)
        chk($sformatf("v%0d latency %0d in 4..6", k, lat), {31'h0, (lat >= 4 && lat <= 6)}, 32'h1);
      if (vecs[k].chk_rd)
        chk($sformatf("v%0d readback", k), {16'h0, rd}, {16'h0, vecs[k].exp_rd});
      chk($sformatf("v%0d miso idle", k), {31'h0, miso}, 32'h0);
    end

    // Reset in the middle of a frame, then finish shifting with ncs still low.
    ncs = 1'b0;
    cyc(5);
    shift_bits(32'h20, 8, rd);
    chk("midframe busy", {31'h0, busy}, 32'h1);
    nrst = 1'b0;
    cyc(1);
    chk("midframe rst regs", regs, 32'h0);
    chk("midframe rst busy", {31'h0, busy}, 32'h0);
    cyc(2);
    nrst = 1'b1;
    shift_bits(32'h11, 8, rd);
    cyc(5);
    ncs = 1'b1;
    observe(fu, uc, lat, ec);
    chk("midframe upd", uc, 0);
    chk("midframe err", ec, 0);
    chk("midframe regs", regs, 32'h0);

    send_frame(32'h2011, 16, rd);
    observe(fu, uc, lat, ec);
    chk("post-reset regs", regs, 32'h00001100);
    chk("post-reset upd", {28'h0, fu}, 32'h2);
    chk("post-reset upd_cycles", uc, 1);
    chk("post-reset err", ec, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
